// File: rtl/present_pkg.sv
// Shared PRESENT definitions: block/key widths, scheduler FSM states and decoder load codes.
package present_pkg;

  localparam int PRESENT_KEY_W  = 80;
  localparam int PRESENT_BLK_W  = 64;
  localparam int PRESENT_ROUNDS = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYLOAD,
    S_KEYWAIT,
    S_ISSUE,
    S_BUSY,
    S_RESULT
  } sched_state_t;

  localparam logic [1:0] PL_KEY  = 2'b10;
  localparam logic [1:0] PL_TEXT = 2'b01;
  localparam logic [1:0] PL_NONE = 2'b00;

endpackage

// File: rtl/present_rr_arb.sv
// Two-way round-robin arbiter. With PRESENT_SCHED_AFFINITY_EN defined it favours the
// requester whose key is resident for up to MAX_BURST consecutive grants.
module present_rr_arb
  import present_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [1:0] i_req,
  input  logic       i_take,
`ifdef PRESENT_SCHED_AFFINITY_EN
  input  logic       i_hint_vld,
  input  logic       i_hint_id,
`endif
  output logic [1:0] o_gnt,
  output logic       o_gnt_id
);

  logic r_last;
  logic w_win;

`ifdef PRESENT_SCHED_AFFINITY_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  logic [BW-1:0] r_burst;
`endif

  always_comb begin
    // Tie-break: the requester granted last loses.
    w_win = ~r_last;
`ifdef PRESENT_SCHED_AFFINITY_EN
    if (i_hint_vld && !(i_hint_id == r_last && r_burst >= BURST_MAX))
      w_win = i_hint_id;
`endif
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = w_win ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
    o_gnt_id = o_gnt[1];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_last <= 1'b1;
    end else if (i_take) begin
      r_last <= o_gnt_id;
    end
  end

`ifdef PRESENT_SCHED_AFFINITY_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_burst <= '0;
    end else if (i_take) begin
      if (o_gnt_id != r_last)
        r_burst <= BW'(1);
      else if (r_burst != BURST_MAX)
        r_burst <= r_burst + BW'(1);
    end
  end
`endif

endmodule

// File: rtl/present_dec_sched.sv
// Shares one PRESENT decoder between two keyed requesters, reloading the key only on
// ownership change. Optional macro PRESENT_SCHED_AFFINITY_EN enables resident-key affinity.
module present_dec_sched
  import present_pkg::*;
#(
  parameter int KEY_WAIT  = 32,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [1:0]   key_we,
  input  logic [159:0] key_data,
  input  logic [1:0]   req_valid,
  input  logic [127:0] req_data,
  output logic [1:0]   req_ready,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [63:0]  rsp_data,
  input  logic         rsp_ready,
  output logic [1:0]   dec_pl,
  output logic [79:0]  dec_in,
  input  logic         dec_done,
  input  logic [63:0]  dec_text
);

  localparam int CNT_W = $clog2(KEY_WAIT + 1);
  localparam logic [CNT_W-1:0] KW_LOAD   = CNT_W'(KEY_WAIT - 1);
  localparam logic [CNT_W-1:0] BUSY_SKIP = CNT_W'(2);

  sched_state_t r_state, w_next;

  logic [PRESENT_KEY_W-1:0] r_key [2];
  logic [1:0]               r_dirty;
  logic                     r_loaded_id;
  logic                     r_loaded_vld;
  logic                     r_gid;
  logic [PRESENT_BLK_W-1:0] r_blk;
  logic [CNT_W-1:0]         r_cnt;
  logic [PRESENT_BLK_W-1:0] r_rsp_data;
  logic                     r_rsp_id;

  logic [1:0] w_gnt;
  logic       w_gnt_id;
  logic       w_take;
  logic       w_hit;
  logic       w_res_id;

  present_rr_arb #(
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clk        (clk),
    .n_reset    (n_reset),
    .i_req      (req_valid),
    .i_take     (w_take),
`ifdef PRESENT_SCHED_AFFINITY_EN
    .i_hint_vld (r_loaded_vld),
    .i_hint_id  (r_loaded_id),
`endif
    .o_gnt      (w_gnt),
    .o_gnt_id   (w_gnt_id)
  );

  assign w_take = (r_state == S_IDLE) && (w_gnt != 2'b00);
  // A key written in the grant cycle forces the reload path so KEYLOAD sees the new key.
  assign w_hit  = r_loaded_vld && (r_loaded_id == w_gnt_id) &&
                  !key_we[w_gnt_id] && !r_dirty[w_gnt_id];

  assign rsp_data = r_rsp_data;
  assign rsp_id   = r_rsp_id;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    dec_pl    = PL_NONE;
    dec_in    = '0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          req_ready = w_gnt;
          w_next    = w_hit ? S_ISSUE : S_KEYLOAD;
        end
      end
      S_KEYLOAD: begin
        dec_pl = PL_KEY;
        dec_in = r_key[r_gid];
        w_next = S_KEYWAIT;
      end
      S_KEYWAIT: begin
        if (r_cnt == '0) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        dec_pl = PL_TEXT;
        dec_in = {16'h0, r_blk};
        w_next = S_BUSY;
      end
      S_BUSY: begin
        if (r_cnt == '0 && dec_done) w_next = S_RESULT;
      end
      S_RESULT: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Block datapath: grant capture, wait counters, result capture.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_gid      <= 1'b0;
      r_blk      <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_rsp_id   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_gid <= w_gnt_id;
            r_blk <= w_gnt_id ? req_data[127:64] : req_data[63:0];
          end
        end
        S_KEYLOAD: r_cnt <= KW_LOAD;
        S_KEYWAIT: if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        // The decoder's done level from the previous block may linger for two samples.
        S_ISSUE:   r_cnt <= BUSY_SKIP;
        S_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (dec_done) begin
            r_rsp_data <= dec_text;
            r_rsp_id   <= r_gid;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_res_id = (r_state == S_KEYLOAD) ? r_gid : r_loaded_id;

  // Key store and residency tracking; a write to the resident key always wins.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_key[0]     <= '0;
      r_key[1]     <= '0;
      r_dirty      <= 2'b00;
      r_loaded_id  <= 1'b0;
      r_loaded_vld <= 1'b0;
    end else begin
      if (r_state == S_KEYLOAD) begin
        r_loaded_id     <= r_gid;
        r_loaded_vld    <= 1'b1;
        r_dirty[r_gid]  <= 1'b0;
      end
      if (key_we[0]) begin
        r_key[0]   <= key_data[79:0];
        r_dirty[0] <= 1'b1;
      end
      if (key_we[1]) begin
        r_key[1]   <= key_data[159:80];
        r_dirty[1] <= 1'b1;
      end
      if (key_we[w_res_id]) r_loaded_vld <= 1'b0;
    end
  end

endmodule
